// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter in front of a 64-byte banked read memory
// Fetch may burst two bytes within its 16-byte bank; data is single-byte only.
module mem_arbiter #(
  parameter int PRIO_RR = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       if_req,
  input  logic [1:0] if_mode,
  input  logic [3:0] if_addr,
  input  logic       if_len2,
  output logic       if_gnt,
  output logic       if_rvalid,
  output logic [7:0] if_rdata,
  input  logic       dm_req,
  input  logic [1:0] dm_mode,
  input  logic [3:0] dm_addr,
  output logic       dm_gnt,
  output logic       dm_rvalid,
  output logic [7:0] dm_rdata,
  output logic [5:0] mem_addr,
  input  logic [7:0] mem_data,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, FETCH1, FETCH2, DATA} state_t;

  state_t     state;
  state_t     state_nx;
  logic [1:0] mode_q;
  logic [3:0] addr_q;
  logic [3:0] addr_inc;
  logic       len2_q;
  logic       last_dm;
  logic       pick_if;
  logic       pick_dm;

  // Tie break: round-robin favours whichever port did not win last time.
  always_comb begin
    pick_if = 1'b0;
    pick_dm = 1'b0;
    if (if_req && dm_req) begin
      if ((PRIO_RR != 0) && !last_dm) pick_dm = 1'b1;
      else                            pick_if = 1'b1;
    end else begin
      pick_if = if_req;
      pick_dm = dm_req;
    end
  end

  // Second burst beat wraps inside the bank, never carrying into mode.
  assign addr_inc = addr_q + 4'd1;

  always_comb begin
    state_nx = state;
    if_gnt   = 1'b0;
    dm_gnt   = 1'b0;
    mem_addr = 6'd0;
    case (state)
      IDLE: begin
        if (!rst) begin
          if (pick_if) begin
            if_gnt   = 1'b1;
            state_nx = FETCH1;
          end else if (pick_dm) begin
            dm_gnt   = 1'b1;
            state_nx = DATA;
          end
        end
      end
      FETCH1: begin
        mem_addr = {mode_q, addr_q};
        state_nx = len2_q ? FETCH2 : IDLE;
      end
      FETCH2: begin
        mem_addr = {mode_q, addr_inc};
        state_nx = IDLE;
      end
      DATA: begin
        mem_addr = {mode_q, addr_q};
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= 2'd0;
      addr_q    <= 4'd0;
      len2_q    <= 1'b0;
      last_dm   <= 1'b1;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if_rdata  <= 8'd0;
      dm_rdata  <= 8'd0;
    end else begin
      state     <= state_nx;
      if_rvalid <= (state == FETCH1) || (state == FETCH2);
      dm_rvalid <= (state == DATA);
      if ((state == FETCH1) || (state == FETCH2)) if_rdata <= mem_data;
      if (state == DATA) dm_rdata <= mem_data;
      if (if_gnt) begin
        mode_q  <= if_mode;
        addr_q  <= if_addr;
        len2_q  <= if_len2;
        last_dm <= 1'b0;
      end else if (dm_gnt) begin
        mode_q  <= dm_mode;
        addr_q  <= dm_addr;
        len2_q  <= 1'b0;
        last_dm <= 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule
